// File: rtl/ulpi_phy_pkg.sv
// rtl/ulpi_phy_pkg.sv - shared types and constants for the ULPI PHY responder
// Purpose: TX CMD codes, register addresses and reset values, RX CMD field
//   offsets, FSM state encoding and small helpers used by the responder and
//   its register file.
// Ports: none (package).
package ulpi_phy_pkg;

  // TX CMD decode of data[7:6] while the link owns the bus
  typedef enum logic [1:0] {
    TX_CMD_NOOP     = 2'b00,
    TX_CMD_TRANSMIT = 2'b01,
    TX_CMD_REGW     = 2'b10,
    TX_CMD_REGR     = 2'b11
  } tx_cmd_t;

  // Register map; each writable register has set (+1) and clear (+2) aliases
  localparam logic [5:0] ADDR_VID_LO    = 6'h00;
  localparam logic [5:0] ADDR_VID_HI    = 6'h01;
  localparam logic [5:0] ADDR_PID_LO    = 6'h02;
  localparam logic [5:0] ADDR_PID_HI    = 6'h03;
  localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
  localparam logic [5:0] ADDR_IFC_CTRL  = 6'h07;
  localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;
  localparam logic [5:0] ADDR_SCRATCH   = 6'h16;

  localparam logic [7:0] FUNC_CTRL_RST = 8'h41;
  localparam logic [7:0] IFC_CTRL_RST  = 8'h00;
  localparam logic [7:0] OTG_CTRL_RST  = 8'h06;
  localparam logic [7:0] SCRATCH_RST   = 8'h00;

  // RX CMD layout: [1:0] LineState, [3:2] VbusState, [5:4] RxEvent, [7:6] ID/int
  localparam int RXCMD_LINESTATE_LSB = 0;
  localparam int RXCMD_VBUS_LSB      = 2;
  localparam int RXCMD_EVENT_LSB     = 4;

  localparam logic [1:0] RX_EVENT_NONE   = 2'b00;
  localparam logic [1:0] RX_EVENT_ACTIVE = 2'b01;

  typedef enum logic [3:0] {
    IDLE,
    TX_DATA,
    TX_FLUSH,
    WR_DATA,
    WR_STP,
    RD_TURN,
    RD_DATA,
    RD_END,
    RX_TURN,
    RX_ACT,
    RX_END,
    RX_TURN2
  } state_t;

  function automatic logic [7:0] rxcmd(input logic [1:0] rx_event,
                                       input logic [1:0] linestate);
    logic [7:0] r;
    r = 8'h00;
    r[RXCMD_LINESTATE_LSB +: 2] = linestate;
    r[RXCMD_VBUS_LSB +: 2]      = 2'b00;
    r[RXCMD_EVENT_LSB +: 2]     = rx_event;
    return r;
  endfunction

  // op: 0 = plain write, 1 = set bits, 2 = clear bits
  function automatic logic [7:0] alias_update(input logic [7:0] cur,
                                              input logic [1:0] op,
                                              input logic [7:0] data);
    case (op)
      2'd0:    return data;
      2'd1:    return cur | data;
      2'd2:    return cur & ~data;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/ulpi_phy_regs.sv
// rtl/ulpi_phy_regs.sv - ULPI PHY register file with ID constants
// Purpose: ID registers 0x00-0x03 always readable. With ULPI_PHY_REGMAP_EN
//   defined, Function Ctrl 0x04, Interface Ctrl 0x07, OTG Ctrl 0x0A and
//   Scratch 0x16 are writable through write/set/clear aliases. Without it,
//   writes are dropped and func_ctrl is the constant reset value.
// Ports:
//   clock, areset_n      clock, async active-low reset
//   wr_en/wr_addr/wr_data one-cycle register write
//   rd_addr/rd_data       combinational read (unmapped -> 8'h00)
//   func_ctrl             current Function Control value
module ulpi_phy_regs #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic       clock,
  input  logic       areset_n,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] func_ctrl
);
  import ulpi_phy_pkg::*;

  logic [7:0] id_data;

  always_comb begin
    id_data = 8'h00;
    case (rd_addr)
      ADDR_VID_LO: id_data = VENDOR_ID[7:0];
      ADDR_VID_HI: id_data = VENDOR_ID[15:8];
      ADDR_PID_LO: id_data = PRODUCT_ID[7:0];
      ADDR_PID_HI: id_data = PRODUCT_ID[15:8];
      default:     id_data = 8'h00;
    endcase
  end

`ifdef ULPI_PHY_REGMAP_EN
  logic [7:0] func_q;
  logic [7:0] ifc_q;
  logic [7:0] otg_q;
  logic [7:0] scr_q;

  function automatic logic hit(input logic [5:0] addr, input logic [5:0] base);
    return (addr >= base) && (addr <= base + 6'd2);
  endfunction

  function automatic logic [1:0] off(input logic [5:0] addr, input logic [5:0] base);
    logic [5:0] d;
    d = addr - base;
    return d[1:0];
  endfunction

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      func_q <= FUNC_CTRL_RST;
      ifc_q  <= IFC_CTRL_RST;
      otg_q  <= OTG_CTRL_RST;
      scr_q  <= SCRATCH_RST;
    end else if (wr_en) begin
      if (hit(wr_addr, ADDR_FUNC_CTRL))
        func_q <= alias_update(func_q, off(wr_addr, ADDR_FUNC_CTRL), wr_data);
      if (hit(wr_addr, ADDR_IFC_CTRL))
        ifc_q <= alias_update(ifc_q, off(wr_addr, ADDR_IFC_CTRL), wr_data);
      if (hit(wr_addr, ADDR_OTG_CTRL))
        otg_q <= alias_update(otg_q, off(wr_addr, ADDR_OTG_CTRL), wr_data);
      if (hit(wr_addr, ADDR_SCRATCH))
        scr_q <= alias_update(scr_q, off(wr_addr, ADDR_SCRATCH), wr_data);
    end
  end

  // Reads at any alias return the underlying register
  always_comb begin
    rd_data = id_data;
    if (hit(rd_addr, ADDR_FUNC_CTRL)) rd_data = func_q;
    if (hit(rd_addr, ADDR_IFC_CTRL))  rd_data = ifc_q;
    if (hit(rd_addr, ADDR_OTG_CTRL))  rd_data = otg_q;
    if (hit(rd_addr, ADDR_SCRATCH))   rd_data = scr_q;
  end

  assign func_ctrl = func_q;
`else
  logic unused_wr;
  assign unused_wr = ^{clock, areset_n, wr_en, wr_addr, wr_data};
  assign rd_data   = id_data;
  assign func_ctrl = FUNC_CTRL_RST;
`endif

endmodule

// File: rtl/ulpi_phy_responder.sv
// rtl/ulpi_phy_responder.sv - PHY end of a ULPI bus for link-side benches
// Purpose: owns dir/nxt, forwards link TX packets to an AXI-S master,
//   turns host AXI-S packets into RX data/RX CMDs, services register
//   read/write. Optional writable register map: ULPI_PHY_REGMAP_EN.
// Ports:
//   clock, areset_n                  60 MHz ULPI clock, async active-low reset
//   ulpi_dir_o/ulpi_nxt_o/ulpi_stp_i ULPI control
//   ulpi_data_i/ulpi_data_o/ulpi_data_oe  ULPI data bus halves and PHY enable
//   linestate_i                      reported in RX CMD[1:0]
//   m_tdata/m_tvalid/m_tready/m_tlast  link->host packets
//   s_tdata/s_tvalid/s_tready/s_tlast  host->link packets
//   func_ctrl_o                      Function Control register
module ulpi_phy_responder #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic       clock,
  input  logic       areset_n,
  output logic       ulpi_dir_o,
  output logic       ulpi_nxt_o,
  input  logic       ulpi_stp_i,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe,
  input  logic [1:0] linestate_i,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic [7:0] m_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic [7:0] s_tdata,
  output logic [7:0] func_ctrl_o
);
  import ulpi_phy_pkg::*;

  state_t     state_q, state_d;
  // High for the single cycle in which nxt acknowledges a REGW/REGR TX CMD
  logic       ack_q, ack_d;
  logic [5:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] skid_q;
  logic       skid_full_q;
  logic       m_tvalid_q;
  logic       m_tlast_q;
  logic [7:0] m_tdata_q;

  logic       can_push;
  logic       cmd_latch;
  logic       tx_accept;
  logic       tx_push;
  logic       tx_push_last;
  logic       wr_capture;
  logic       reg_write;
  logic [7:0] rd_data;

  assign can_push = !m_tvalid_q || m_tready;

  ulpi_phy_regs #(
    .VENDOR_ID (VENDOR_ID),
    .PRODUCT_ID(PRODUCT_ID)
  ) u_regs (
    .clock    (clock),
    .areset_n (areset_n),
    .wr_en    (reg_write),
    .wr_addr  (addr_q),
    .wr_data  (wdata_q),
    .rd_addr  (addr_q),
    .rd_data  (rd_data),
    .func_ctrl(func_ctrl_o)
  );

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ack_d        = 1'b0;
    ulpi_dir_o   = 1'b0;
    ulpi_nxt_o   = 1'b0;
    ulpi_data_oe = 1'b0;
    ulpi_data_o  = 8'h00;
    s_tready     = 1'b0;
    cmd_latch    = 1'b0;
    tx_accept    = 1'b0;
    tx_push      = 1'b0;
    tx_push_last = 1'b0;
    wr_capture   = 1'b0;
    reg_write    = 1'b0;

    case (state_q)
      IDLE: begin
        // Host data wins; a colliding link TX CMD is dropped and retried
        if (s_tvalid) begin
          state_d = RX_TURN;
        end else if (ulpi_data_i != 8'h00) begin
          cmd_latch = 1'b1;
          case (tx_cmd_t'(ulpi_data_i[7:6]))
            TX_CMD_TRANSMIT: state_d = TX_DATA;
            TX_CMD_REGW: begin
              state_d = WR_DATA;
              ack_d   = 1'b1;
            end
            TX_CMD_REGR: begin
              state_d = RD_TURN;
              ack_d   = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      TX_DATA: begin
        // The TX CMD byte itself is the first byte accepted; one byte is
        // always held back so tlast can be attached when stp arrives.
        if (ulpi_stp_i) begin
          state_d = TX_FLUSH;
        end else begin
          ulpi_nxt_o = !skid_full_q || can_push;
          tx_accept  = ulpi_nxt_o;
          tx_push    = ulpi_nxt_o && skid_full_q;
        end
      end
      TX_FLUSH: begin
        if (!skid_full_q) begin
          state_d = IDLE;
        end else if (can_push) begin
          tx_push      = 1'b1;
          tx_push_last = 1'b1;
          state_d      = IDLE;
        end
      end
      WR_DATA: begin
        ulpi_nxt_o = 1'b1;
        if (!ack_q) begin
          wr_capture = 1'b1;
          state_d    = WR_STP;
        end
      end
      WR_STP: begin
        reg_write = ulpi_stp_i;
        state_d   = IDLE;
      end
      RD_TURN: begin
        if (ack_q) begin
          ulpi_nxt_o = 1'b1;
        end else begin
          ulpi_dir_o = 1'b1;
          state_d    = RD_DATA;
        end
      end
      RD_DATA: begin
        ulpi_dir_o   = 1'b1;
        ulpi_data_oe = 1'b1;
        ulpi_data_o  = rd_data;
        state_d      = RD_END;
      end
      RD_END: state_d = IDLE;
      RX_TURN: begin
        ulpi_dir_o = 1'b1;
        ulpi_nxt_o = 1'b1;
        state_d    = RX_ACT;
      end
      RX_ACT: begin
        ulpi_dir_o   = 1'b1;
        ulpi_data_oe = 1'b1;
        s_tready     = 1'b1;
        if (s_tvalid) begin
          ulpi_nxt_o  = 1'b1;
          ulpi_data_o = s_tdata;
          if (s_tlast) state_d = RX_END;
        end else begin
          ulpi_data_o = rxcmd(RX_EVENT_ACTIVE, linestate_i);
        end
      end
      RX_END: begin
        ulpi_dir_o   = 1'b1;
        ulpi_data_oe = 1'b1;
        ulpi_data_o  = rxcmd(RX_EVENT_NONE, linestate_i);
        state_d      = RX_TURN2;
      end
      RX_TURN2: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      addr_q      <= 6'h00;
      wdata_q     <= 8'h00;
      skid_q      <= 8'h00;
      skid_full_q <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= 8'h00;
    end else begin
      if (cmd_latch) begin
        addr_q      <= ulpi_data_i[5:0];
        skid_full_q <= 1'b0;
      end
      if (tx_accept) begin
        skid_q      <= ulpi_data_i;
        skid_full_q <= 1'b1;
      end else if (tx_push_last) begin
        skid_full_q <= 1'b0;
      end
      if (tx_push) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= skid_q;
        m_tlast_q  <= tx_push_last;
      end else if (m_tready) begin
        m_tvalid_q <= 1'b0;
      end
      if (wr_capture) wdata_q <= ulpi_data_i;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tdata  = m_tdata_q;

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// tb/tb_ulpi_phy_responder.sv - directed self-checking bench for ulpi_phy_responder
module tb_ulpi_phy_responder;

  logic       clock = 1'b0;
  logic       areset_n;
  logic       ulpi_dir_o, ulpi_nxt_o, ulpi_stp_i, ulpi_data_oe;
  logic [7:0] ulpi_data_i, ulpi_data_o;
  logic [1:0] linestate_i;
  logic       m_tvalid, m_tready, m_tlast;
  logic [7:0] m_tdata;
  logic       s_tvalid, s_tready, s_tlast;
  logic [7:0] s_tdata;
  logic [7:0] func_ctrl_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [8:0] m_q[$];
  logic [8:0] exp2[5] = '{9'h04B, 9'h011, 9'h022, 9'h033, 9'h144};

`ifdef ULPI_PHY_REGMAP_EN
  localparam logic [7:0] FC_SET = 8'h45;
  localparam logic [7:0] RD_FC  = 8'h45;
  localparam logic [7:0] RD_SCR = 8'h5A;
  localparam logic [7:0] RD_SCR_CLR = 8'h50;
`else
  localparam logic [7:0] FC_SET = 8'h41;
  localparam logic [7:0] RD_FC  = 8'h00;
  localparam logic [7:0] RD_SCR = 8'h00;
  localparam logic [7:0] RD_SCR_CLR = 8'h00;
`endif

  ulpi_phy_responder dut (
    .clock       (clock),
    .areset_n    (areset_n),
    .ulpi_dir_o  (ulpi_dir_o),
    .ulpi_nxt_o  (ulpi_nxt_o),
    .ulpi_stp_i  (ulpi_stp_i),
    .ulpi_data_i (ulpi_data_i),
    .ulpi_data_o (ulpi_data_o),
    .ulpi_data_oe(ulpi_data_oe),
    .linestate_i (linestate_i),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tdata     (m_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .s_tdata     (s_tdata),
    .func_ctrl_o (func_ctrl_o)
  );

  initial forever #5 clock = ~clock;

  // Handshake sampled mid-cycle; inputs only change just after posedge
  always @(negedge clock)
    if (areset_n && m_tvalid && m_tready) m_q.push_back({m_tlast, m_tdata});

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic d, input logic n, input logic o,
                     input logic [7:0] v);
    chk(tag, {5'b0, ulpi_dir_o, ulpi_nxt_o, ulpi_data_oe, ulpi_data_o},
        {5'b0, d, n, o, v});
  endtask

  task automatic mchk(input string tag, input logic v, input logic l, input logic [7:0] d);
    chk(tag, {6'b0, m_tvalid, m_tlast, m_tdata}, {6'b0, v, l, d});
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_read(input logic [5:0] a, input logic [7:0] exp, input string tag);
    step(); ulpi_data_i = {2'b11, a}; #1; bus({tag, " cmd"}, 0, 0, 0, 8'h00);
    step(); #1; bus({tag, " ack"}, 0, 1, 0, 8'h00);
    step(); ulpi_data_i = 8'h00; #1; bus({tag, " turn"}, 1, 0, 0, 8'h00);
    step(); #1; bus({tag, " data"}, 1, 0, 1, exp);
    step(); #1; bus({tag, " end"}, 0, 0, 0, 8'h00);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d, input logic with_stp,
                          input string tag);
    step(); ulpi_data_i = {2'b10, a}; #1;
    step(); #1; chk({tag, " ack nxt"}, ulpi_nxt_o, 1);
    step(); ulpi_data_i = d; #1; chk({tag, " data nxt"}, ulpi_nxt_o, 1);
    step(); ulpi_data_i = 8'h00; ulpi_stp_i = with_stp; #1; chk({tag, " stp nxt"}, ulpi_nxt_o, 0);
    step(); ulpi_stp_i = 1'b0; #1;
  endtask

  initial begin
    areset_n = 1'b0; ulpi_stp_i = 1'b0; ulpi_data_i = 8'h00; linestate_i = 2'b01;
    m_tready = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
    #12;
    bus("reset bus", 0, 0, 0, 8'h00);
    chk("reset m_tvalid", m_tvalid, 0);
    chk("reset s_tready", s_tready, 0);
    chk("reset func_ctrl", func_ctrl_o, 8'h41);
    step(); areset_n = 1'b1; #1;

    // 1: TX 43 AA 55 + stp
    m_q.delete();
    step(); ulpi_data_i = 8'h43; #1; chk("tx1 idle nxt", ulpi_nxt_o, 0);
    step(); #1; chk("tx1 cmd nxt", ulpi_nxt_o, 1);
    step(); ulpi_data_i = 8'hAA; #1; chk("tx1 AA nxt", ulpi_nxt_o, 1); chk("tx1 m empty", m_tvalid, 0);
    step(); ulpi_data_i = 8'h55; #1; chk("tx1 55 nxt", ulpi_nxt_o, 1); mchk("tx1 m 43", 1, 0, 8'h43);
    step(); ulpi_data_i = 8'h00; ulpi_stp_i = 1'b1; #1; mchk("tx1 m AA", 1, 0, 8'hAA);
    step(); ulpi_stp_i = 1'b0; #1; chk("tx1 flush gap", m_tvalid, 0);
    step(); #1; mchk("tx1 m 55 last", 1, 1, 8'h55);
    step(); #1; chk("tx1 m drained", m_tvalid, 0);
    chk("tx1 pkt len", m_q.size(), 3);
    chk("tx1 q0", m_q[0], 9'h043);
    chk("tx1 q1", m_q[1], 9'h0AA);
    chk("tx1 q2", m_q[2], 9'h155);

    // 2: backpressure for 4 cycles mid-packet
    m_q.delete();
    step(); ulpi_data_i = 8'h4B; #1;
    step(); #1; chk("bp cmd nxt", ulpi_nxt_o, 1);
    step(); ulpi_data_i = 8'h11; #1; chk("bp 11 nxt", ulpi_nxt_o, 1);
    step(); ulpi_data_i = 8'h22; #1; chk("bp 22 nxt", ulpi_nxt_o, 1);
    step(); ulpi_data_i = 8'h33; m_tready = 1'b0; #1; chk("bp stall0 nxt", ulpi_nxt_o, 0);
    for (int i = 1; i < 4; i++) begin
      step(); #1;
      chk("bp stall nxt", ulpi_nxt_o, 0);
      mchk("bp stall m hold", 1, 0, 8'h11);
    end
    step(); m_tready = 1'b1; #1; chk("bp resume nxt", ulpi_nxt_o, 1);
    step(); ulpi_data_i = 8'h44; #1; chk("bp 44 nxt", ulpi_nxt_o, 1);
    step(); ulpi_data_i = 8'h00; ulpi_stp_i = 1'b1; #1;
    step(); ulpi_stp_i = 1'b0; #1;
    step(); #1; mchk("bp m 44 last", 1, 1, 8'h44);
    step(); #1;
    chk("bp pkt len", m_q.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp pkt byte", m_q[i], exp2[i]);

    // 3: register reads, including unmapped
    do_read(6'h00, 8'h24, "rd vid lo");
    do_read(6'h01, 8'h04, "rd vid hi");
    do_read(6'h02, 8'h09, "rd pid lo");
    do_read(6'h20, 8'h00, "rd unmapped");

    // 4: writes via set/clear aliases, and a write lacking stp
    do_write(6'h05, 8'h04, 1'b1, "wr set fc");
    chk("wr set fc value", func_ctrl_o, FC_SET);
    do_write(6'h06, 8'h04, 1'b0, "wr no stp");
    chk("wr no stp value", func_ctrl_o, FC_SET);
    do_read(6'h04, RD_FC, "rd fc");
    do_write(6'h16, 8'h5A, 1'b1, "wr scratch");
    do_read(6'h16, RD_SCR, "rd scratch");
    do_write(6'h18, 8'h0F, 1'b1, "wr scratch clr");
    do_read(6'h17, RD_SCR_CLR, "rd scratch alias");

    // zero-payload TX -> single-byte packet
    m_q.delete();
    step(); ulpi_data_i = 8'h4C; #1;
    step(); #1; chk("tx0 cmd nxt", ulpi_nxt_o, 1);
    step(); ulpi_data_i = 8'h00; ulpi_stp_i = 1'b1; #1;
    step(); ulpi_stp_i = 1'b0; #1;
    step(); #1; mchk("tx0 m 4C last", 1, 1, 8'h4C);
    step(); #1; chk("tx0 pkt len", m_q.size(), 1);

    // 5: RX C3 01 <gap 2> 02(last)
    step(); s_tvalid = 1'b1; s_tdata = 8'hC3; s_tlast = 1'b0; #1;
    bus("rx idle", 0, 0, 0, 8'h00); chk("rx idle s_tready", s_tready, 0);
    step(); #1; bus("rx turn", 1, 1, 0, 8'h00); chk("rx turn s_tready", s_tready, 0);
    step(); #1; bus("rx C3", 1, 1, 1, 8'hC3); chk("rx act s_tready", s_tready, 1);
    step(); s_tdata = 8'h01; #1; bus("rx 01", 1, 1, 1, 8'h01);
    step(); s_tvalid = 1'b0; s_tdata = 8'h00; #1; bus("rx gap1 rxcmd", 1, 0, 1, 8'h11);
    step(); #1; bus("rx gap2 rxcmd", 1, 0, 1, 8'h11);
    step(); s_tvalid = 1'b1; s_tdata = 8'h02; s_tlast = 1'b1; #1; bus("rx 02", 1, 1, 1, 8'h02);
    step(); s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; #1; bus("rx end rxcmd", 1, 0, 1, 8'h01);
    step(); #1; bus("rx turn2", 0, 0, 0, 8'h00);
    step(); #1; bus("rx back idle", 0, 0, 0, 8'h00);

    // 6: collision, then reset mid-RX
    step(); s_tvalid = 1'b1; s_tdata = 8'hA5; ulpi_data_i = 8'h41; #1;
    step(); ulpi_data_i = 8'h00; #1;
    bus("col turn", 1, 1, 0, 8'h00); chk("col m_tvalid", m_tvalid, 0);
    step(); #1; bus("col rx A5", 1, 1, 1, 8'hA5); chk("col m_tvalid act", m_tvalid, 0);
    areset_n = 1'b0; s_tvalid = 1'b0; #1;
    bus("rst rx bus", 0, 0, 0, 8'h00);
    chk("rst rx s_tready", s_tready, 0);
    chk("rst rx m_tvalid", m_tvalid, 0);
    step(); areset_n = 1'b1; #1; bus("rst rx idle", 0, 0, 0, 8'h00);

    // reset mid-TX drops the partial packet
    m_q.delete();
    step(); ulpi_data_i = 8'h4D; #1;
    step(); #1;
    step(); ulpi_data_i = 8'h99; #1;
    step(); m_tready = 1'b0; #1;
    mchk("rst tx m 4D", 1, 0, 8'h4D);
    chk("rst tx stall nxt", ulpi_nxt_o, 0);
    areset_n = 1'b0; #1;
    chk("rst tx m_tvalid", m_tvalid, 0);
    chk("rst tx nxt", ulpi_nxt_o, 0);
    chk("rst tx func_ctrl", func_ctrl_o, 8'h41);
    step(); areset_n = 1'b1; ulpi_data_i = 8'h00; m_tready = 1'b1; #1;
    step(); #1;
    chk("rst tx m after", m_tvalid, 0);
    chk("rst tx no pkt", m_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
